// File: rtl/pe_tile_param.sv
// pe_tile_param: one tile of a configurable fabric. It has two connection boxes
// that feed a small PE, and a switch box that drives every outgoing track.
// A memory-mapped config port sets up routing and the PE.
// An access hits this tile when config_addr[15:0] matches tile_id.
// The target register is selected by config_addr[31:16]:
//   4 = PE {oreg, op}, 5 = cb1 sel, 6 = cb0 sel, 7 = sb entry [config_data[31:24]].
module pe_tile_param #(
    parameter int WIDTH  = 16,
    parameter int TRACKS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 config_addr,
    input  logic [31:0]                 config_data,
    input  logic                        config_we,
    input  logic                        config_re,
    input  logic [15:0]                 tile_id,
    input  logic [4*TRACKS*WIDTH-1:0]   in_wires,
    output logic [4*TRACKS*WIDTH-1:0]   out_wires,
    output logic [31:0]                 config_rdata,
    output logic                        config_rvalid
);

    localparam int NOUT = 4 * TRACKS;
    localparam int TW   = $clog2(TRACKS);
    localparam int SELW = $clog2(2 * TRACKS);
    localparam int IW   = $clog2(NOUT);

    logic [2:0]        r_op;
    logic              r_oreg;
    logic [SELW-1:0]   r_cb0_sel;
    logic [SELW-1:0]   r_cb1_sel;
    logic [2:0]        r_sb [NOUT];
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_pe_q;
    logic [31:0]       r_rdata;
    logic              r_rvalid;

    logic              w_hit;
    logic [15:0]       w_tgt;
    logic              w_wr;
    logic              w_rd;
    logic              w_wr_pe;
    logic [7:0]        w_sb_idx;
    logic              w_idx_ok;
    logic [IW-1:0]     w_sb_ptr;
    logic [WIDTH-1:0]  w_in [4][TRACKS];
    logic [WIDTH-1:0]  w_fb [4][TRACKS];
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_mul;
    logic [WIDTH-1:0]  w_result;
    logic [WIDTH-1:0]  w_pe_out;
    logic              w_rd_ok;
    logic [31:0]       w_rd_val;
    logic              w_unused;

    assign w_hit    = (config_addr[15:0] == tile_id);
    assign w_tgt    = config_addr[31:16];
    assign w_wr     = w_hit & config_we;
    assign w_rd     = w_hit & config_re;
    assign w_wr_pe  = w_wr && (w_tgt == 16'd4);
    assign w_sb_idx = config_data[31:24];
    assign w_idx_ok = ({24'd0, w_sb_idx} < 32'(NOUT));
    assign w_sb_ptr = w_sb_idx[IW-1:0];
    assign w_unused = ^{config_data[23:5], config_data[3]};

    // Switch box: one mux per outgoing track. Entries 1..3 pick the same track
    // on the other sides, in ascending side order.
    for (genvar gs = 0; gs < 4; gs++) begin : g_side
        localparam int O1 = (gs == 0) ? 1 : 0;
        localparam int O2 = (gs <= 1) ? 2 : 1;
        localparam int O3 = (gs <= 2) ? 3 : 2;
        for (genvar gt = 0; gt < TRACKS; gt++) begin : g_trk
            localparam int IDX = gs * TRACKS + gt;
            logic [WIDTH-1:0] w_src;
            logic             w_is_pe;

            assign w_in[gs][gt] = in_wires[IDX*WIDTH +: WIDTH];
            assign w_is_pe      = (r_sb[IDX] == 3'd4);

            // Select a neighbouring input track, or zero for unused codes
            always_comb begin
                w_src = '0;
                case (r_sb[IDX])
                    3'd1:    w_src = w_in[O1][gt];
                    3'd2:    w_src = w_in[O2][gt];
                    3'd3:    w_src = w_in[O3][gt];
                    default: w_src = '0;
                endcase
            end

            assign out_wires[IDX*WIDTH +: WIDTH] = w_is_pe ? w_pe_out : w_src;
            // A connection box reading an output track sees the same value,
            // except that the PE source is taken from the registered result.
            // This avoids a combinational loop through the PE.
            assign w_fb[gs][gt] = w_is_pe ? r_pe_q : w_src;
        end
    end

    // In the connection box selects, the top bit chooses output tracks over input tracks
    assign w_a = r_cb0_sel[SELW-1] ? w_fb[0][r_cb0_sel[TW-1:0]] : w_in[0][r_cb0_sel[TW-1:0]];
    assign w_b = r_cb1_sel[SELW-1] ? w_fb[1][r_cb1_sel[TW-1:0]] : w_in[1][r_cb1_sel[TW-1:0]];

    // PE datapath, all results wrap at WIDTH bits
    always_comb begin
        w_mul    = w_a * w_b;
        w_result = w_a;
        case (r_op)
            3'd0:    w_result = w_a + w_b;
            3'd1:    w_result = w_a - w_b;
            3'd2:    w_result = w_a & w_b;
            3'd3:    w_result = w_a | w_b;
            3'd4:    w_result = w_a ^ w_b;
            3'd5:    w_result = w_mul;
            3'd6:    w_result = r_acc;
            default: w_result = w_a;
        endcase
    end

    assign w_pe_out = r_oreg ? r_pe_q : w_result;

    // Configuration register writes, only on a tile hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= '0;
            r_oreg    <= 1'b0;
            r_cb0_sel <= '0;
            r_cb1_sel <= '0;
            for (int i = 0; i < NOUT; i++) r_sb[i] <= '0;
        end else if (w_wr) begin
            case (w_tgt)
                16'd4: begin
                    r_op   <= config_data[2:0];
                    r_oreg <= config_data[4];
                end
                16'd5:   r_cb1_sel <= config_data[SELW-1:0];
                16'd6:   r_cb0_sel <= config_data[SELW-1:0];
                16'd7:   if (w_idx_ok) r_sb[w_sb_ptr] <= config_data[2:0];
                default: ;
            endcase
        end
    end

    // Accumulator and output register. Any PE config write restarts the MAC from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_pe_q <= '0;
        end else begin
            r_pe_q <= w_result;
            if (w_wr_pe)
                r_acc <= '0;
            else if (r_op == 3'd6)
                r_acc <= r_acc + w_mul;
        end
    end

    // Readback decode. Register values are sampled before any same-cycle write lands.
    always_comb begin
        w_rd_ok  = 1'b0;
        w_rd_val = '0;
        if (w_rd) begin
            case (w_tgt)
                16'd4: begin
                    w_rd_ok  = 1'b1;
                    w_rd_val = {27'd0, r_oreg, 1'b0, r_op};
                end
                16'd5: begin
                    w_rd_ok  = 1'b1;
                    w_rd_val = 32'(r_cb1_sel);
                end
                16'd6: begin
                    w_rd_ok  = 1'b1;
                    w_rd_val = 32'(r_cb0_sel);
                end
                16'd7: begin
                    if (w_idx_ok) begin
                        w_rd_ok  = 1'b1;
                        w_rd_val = 32'(r_sb[w_sb_ptr]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Readback response is registered, giving a one-cycle latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd_ok;
            r_rdata  <= w_rd_val;
        end
    end

    assign config_rvalid = r_rvalid;
    assign config_rdata  = r_rdata;

endmodule

// File: tb/tb_pe_tile_param.sv
// Scoreboard bench for pe_tile_param (WIDTH=16, TRACKS=4).
// Stimulus pushes the expected track values and readbacks into queues,
// and a negedge monitor pops them and compares.
// Lane 16 in the track queue means "no readback response": rvalid and rdata must both be zero.
module tb_pe_tile_param;

    localparam int          W    = 16;
    localparam int          T    = 4;
    localparam logic [15:0] TILE = 16'h0012;

    logic               clk;
    logic               reset;
    logic [31:0]        config_addr;
    logic [31:0]        config_data;
    logic               config_we;
    logic               config_re;
    logic [4*T*W-1:0]   in_wires;
    logic [4*T*W-1:0]   out_wires;
    logic [31:0]        config_rdata;
    logic               config_rvalid;

    typedef struct { int cyc; int lane; logic [31:0] val; } ow_t;
    typedef struct { int cyc; logic [31:0] val; } rd_t;

    ow_t ow_q[$];
    rd_t rd_q[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    pe_tile_param #(.WIDTH(W), .TRACKS(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .config_we     (config_we),
        .config_re     (config_re),
        .tile_id       (TILE),
        .in_wires      (in_wires),
        .out_wires     (out_wires),
        .config_rdata  (config_rdata),
        .config_rvalid (config_rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    // Monitor: readback responses and scheduled track checks
    always @(negedge clk) begin
        rd_t e;
        logic [15:0] got;
        if (config_rvalid) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got rvalid with rdata=%h, required no response", config_rdata);
            end else begin
                e = rd_q.pop_front();
                if (e.cyc != cyc || config_rdata !== e.val) begin
                    n_fail++;
                    $display("FAIL readback: got rdata=%h at cycle %0d, required %h at cycle %0d",
                             config_rdata, cyc, e.val, e.cyc);
                end
            end
        end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            e = rd_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL rd_missing: no rvalid at cycle %0d, required rdata=%h", cyc, e.val);
        end
        for (int i = ow_q.size() - 1; i >= 0; i--) begin
            if (ow_q[i].cyc <= cyc) begin
                n_tests++;
                if (ow_q[i].lane == 16) begin
                    if (config_rvalid !== 1'b0 || config_rdata !== 32'd0) begin
                        n_fail++;
                        $display("FAIL rd_none: got rvalid=%b rdata=%h, required 0/0", config_rvalid, config_rdata);
                    end
                end else begin
                    got = out_wires[ow_q[i].lane*W +: W];
                    if (ow_q[i].cyc != cyc || got !== ow_q[i].val[15:0]) begin
                        n_fail++;
                        $display("FAIL out_lane%0d: got %h at cycle %0d, required %h at cycle %0d",
                                 ow_q[i].lane, got, cyc, ow_q[i].val[15:0], ow_q[i].cyc);
                    end
                end
                ow_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ow(input int lane, input logic [31:0] val, input int dly);
        ow_t x;
        x.cyc  = cyc + dly;
        x.lane = lane;
        x.val  = val;
        ow_q.push_back(x);
    endtask

    task automatic set_in(input int lane, input logic [15:0] val);
        in_wires[lane*W +: W] = val;
    endtask

    task automatic wr_tile(input logic [15:0] tid, input logic [15:0] tgt, input logic [31:0] d);
        config_addr = {tgt, tid};
        config_data = d;
        config_we   = 1'b1;
        tick();
        config_we   = 1'b0;
    endtask

    task automatic wr(input logic [15:0] tgt, input logic [31:0] d);
        wr_tile(TILE, tgt, d);
    endtask

    task automatic rd(input logic [15:0] tgt, input logic [31:0] d, input logic [31:0] expv);
        rd_t x;
        config_addr = {tgt, TILE};
        config_data = d;
        config_re   = 1'b1;
        x.cyc = cyc + 1;
        x.val = expv;
        rd_q.push_back(x);
        tick();
        config_re   = 1'b0;
    endtask

    task automatic rd_none(input logic [15:0] tid, input logic [15:0] tgt);
        config_addr = {tgt, tid};
        config_data = 32'd0;
        config_re   = 1'b1;
        exp_ow(16, 32'd0, 1);
        tick();
        config_re   = 1'b0;
    endtask

    initial begin
        logic [15:0] op_v  [7];
        logic [15:0] exp_v [7];
        rd_t x;
        op_v  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7};
        exp_v = '{16'h2143, 16'h0325, 16'h0204, 16'h1F3F, 16'h1D3B, 16'h1D0C, 16'h1234};

        reset = 1'b0;
        config_addr = '0;
        config_data = '0;
        config_we = 1'b0;
        config_re = 1'b0;
        in_wires = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Routing: add into lane 0, plus the neighbour-track selections of the switch box
        wr(6, 32'h0);
        wr(5, 32'h0);
        wr(4, 32'h0);
        wr(7, 32'h0000_0004);
        wr(7, 32'h0100_0002);
        wr(7, 32'h0600_0001);
        wr(7, 32'h0E00_0003);
        wr(7, 32'h0300_0005);
        set_in(0, 16'h0003);
        set_in(4, 16'h0005);
        set_in(9, 16'h1234);
        set_in(2, 16'hABCD);
        set_in(10, 16'h5555);
        set_in(7, 16'h7777);
        exp_ow(0, 32'h0008, 0);
        exp_ow(1, 32'h1234, 0);
        exp_ow(6, 32'hABCD, 0);
        exp_ow(14, 32'h5555, 0);
        exp_ow(3, 32'h0000, 0);
        exp_ow(2, 32'h0000, 0);
        tick();

        // ALU ops with a=0x1234, b=0x0F0F
        set_in(0, 16'h1234);
        set_in(4, 16'h0F0F);
        for (int i = 0; i < 7; i++) begin
            wr(4, {16'd0, op_v[i]});
            exp_ow(0, {16'd0, exp_v[i]}, 0);
        end

        // Connection boxes reading output tracks
        wr(6, 32'h5);
        wr(5, 32'h6);
        wr(4, 32'h0);
        exp_ow(0, 32'hBE01, 0);
        wr(6, 32'h0);
        wr(5, 32'h0);

        // Registered output wraps; the result appears one cycle after the operands change
        wr(4, 32'h10);
        set_in(0, 16'hFFFF);
        set_in(4, 16'h0002);
        exp_ow(0, 32'h2143, 0);
        exp_ow(0, 32'h0001, 1);
        tick();

        // MAC sequence, then restart by rewriting op 6
        wr(4, 32'h0);
        set_in(0, 16'h0002);
        set_in(4, 16'h0003);
        exp_ow(0, 32'd0, 1);
        exp_ow(0, 32'd6, 2);
        exp_ow(0, 32'd24, 5);
        wr(4, 32'h6);
        repeat (4) tick();
        exp_ow(0, 32'd0, 1);
        exp_ow(0, 32'd6, 2);
        wr(4, 32'h6);
        tick();
        tick();

        // Asynchronous reset with random inputs clears every output
        for (int i = 0; i < 4*T; i++) set_in(i, 16'($urandom));
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4*T; i++) exp_ow(i, 32'd0, 0);
        exp_ow(16, 32'd0, 0);
        tick();
        tick();
        reset = 1'b1;
        in_wires = '0;
        tick();

        // After reset, op is back to 0 and no accumulation resumes
        wr(7, 32'h0000_0004);
        set_in(0, 16'h0002);
        set_in(4, 16'h0003);
        exp_ow(0, 32'd5, 0);
        rd(4, 32'h0, 32'h0);

        // Tile-id mismatch and out-of-range sb index are ignored
        wr_tile(16'h0013, 7, 32'h0000_0001);
        exp_ow(0, 32'd5, 0);
        rd(7, 32'h0000_0000, 32'h4);
        wr(7, 32'h1000_0001);
        exp_ow(0, 32'd5, 0);
        rd(7, 32'h0000_0000, 32'h4);
        rd_none(16'h0013, 4);
        rd_none(TILE, 9);

        // Readback, including a read and a write to the same register in one cycle
        wr(7, 32'h0500_0003);
        rd(7, 32'h0500_0000, 32'h3);
        config_addr = {16'd7, TILE};
        config_data = 32'h0500_0001;
        config_we = 1'b1;
        config_re = 1'b1;
        x.cyc = cyc + 1;
        x.val = 32'h3;
        rd_q.push_back(x);
        tick();
        config_we = 1'b0;
        config_re = 1'b0;
        rd(7, 32'h0500_0000, 32'h1);
        rd(6, 32'h0, 32'h0);
        wr(6, 32'h3);
        rd(6, 32'h0, 32'h3);
        wr(4, 32'h16);
        rd(4, 32'h0, 32'h16);

        repeat (3) tick();
        if (rd_q.size() != 0 || ow_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: got %0d readbacks and %0d track checks pending, required 0", rd_q.size(), ow_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
